// File: rtl/mdu_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctr
// Description : Multi-cycle multiply/divide unit with its own HI/LO-class
//               R-type decode (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI,
//               MTLO). An iterative WIDTH-step shift-add multiplier or
//               restoring divider is followed by one sign-fix cycle.
//               Optional macro MDU_DIV0_TRAP_EN adds a div0 output and
//               suppresses the HI/LO write on divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctr #(
    parameter int         WIDTH = 32,
    parameter logic [1:0] RTYPE = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result,
`ifdef MDU_DIV0_TRAP_EN
    output logic             div0,
`endif
    output logic             hilo_rd
);

    localparam int         CW          = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST   = CW'(WIDTH - 1);

    localparam logic [5:0] c_FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] c_FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] c_FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] c_FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] c_FUNC_MULT  = 6'b011000;
    localparam logic [5:0] c_FUNC_MULTU = 6'b011001;
    localparam logic [5:0] c_FUNC_DIV   = 6'b011010;
    localparam logic [5:0] c_FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Iteration registers: rem holds the running partial product high half /
    // partial remainder, quo holds multiplier / dividend bits being shifted out.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Decode
    logic             w_rtype;
    logic             w_muldiv;
    logic             w_go;
    logic             w_mt_go;
    logic             w_signed;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    // Step and fix-up datapath
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic               w_dge;
    logic [WIDTH-1:0]   w_ddiff;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_rtype  = (ALUop == RTYPE);
    assign w_muldiv = (func == c_FUNC_MULT) || (func == c_FUNC_MULTU) ||
                      (func == c_FUNC_DIV)  || (func == c_FUNC_DIVU);
    assign w_go     = (state_q == S_IDLE) && start && w_rtype && w_muldiv;
    assign w_mt_go  = (state_q == S_IDLE) && start && w_rtype &&
                      ((func == c_FUNC_MTHI) || (func == c_FUNC_MTLO));

    // Even codes (MULT, DIV) are the signed variants; bit 1 selects divide.
    assign w_signed = ~func[0];
    assign w_is_div = func[1];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    // The most-negative value maps onto itself, which read unsigned is its magnitude.
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Multiply step: conditional add then shift the {rem,quo} pair right.
    assign w_addend = quo_q[0] ? opb_q : '0;
    assign w_msum   = {1'b0, rem_q} + {1'b0, w_addend};

    // Divide step: shift in the next dividend bit and trial-subtract.
    assign w_dshift = {rem_q, quo_q[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, opb_q});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - opb_q;

    assign w_rem_step = div_q ? (w_dge ? w_ddiff : w_dshift[WIDTH-1:0])
                              : w_msum[WIDTH:1];
    assign w_quo_step = div_q ? {quo_q[WIDTH-2:0], w_dge}
                              : {w_msum[0], quo_q[WIDTH-1:1]};

    // With a zero divisor every trial succeeds, so rem ends up holding |a|
    // and quo all ones; only the quotient needs overriding in the fix cycle.
    assign w_prod     = {rem_q, quo_q};
    assign w_prod_fix = qneg_q ? -w_prod : w_prod;
    assign w_quo_fix  = qneg_q ? -quo_q : quo_q;
    assign w_rem_fix  = rneg_q ? -rem_q : rem_q;

    // Combinational HI/LO read port
    assign hilo_rd = w_rtype && ((func == c_FUNC_MFHI) || (func == c_FUNC_MFLO));
    assign result  = !hilo_rd              ? '0   :
                     (func == c_FUNC_MFHI) ? hi_q : lo_q;

    assign hi = hi_q;
    assign lo = lo_q;

    // FSM next-state and handshake outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef MDU_DIV0_TRAP_EN
        div0    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_go) state_d = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt_q == c_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                busy    = 1'b1;
                done    = 1'b1;
`ifdef MDU_DIV0_TRAP_EN
                div0    = dz_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: operand latch, iteration step, sign fix and MTHI/MTLO
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_go) begin
                    rem_d  = '0;
                    quo_d  = w_a_mag;
                    opb_d  = w_b_mag;
                    cnt_d  = '0;
                    div_d  = w_is_div;
                    qneg_d = w_a_neg ^ w_b_neg;
                    rneg_d = w_a_neg;
                    dz_d   = w_is_div && (b == '0);
                end else if (w_mt_go) begin
                    if (func == c_FUNC_MTHI) hi_d = a;
                    else                     lo_d = a;
                end
            end
            S_CALC: begin
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
`ifdef MDU_DIV0_TRAP_EN
                if (!dz_q) begin
`else
                begin
`endif
                    if (div_q) begin
                        hi_d = w_rem_fix;
                        lo_d = dz_q ? {WIDTH{1'b1}} : w_quo_fix;
                    end else begin
                        hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = w_prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctr
// Description : Directed self-checking bench for mdu_ctr (WIDTH=32).
//               Honours MDU_DIV0_TRAP_EN for the divide-by-zero vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctr;

    localparam int         W     = 32;
    localparam logic [1:0] RT    = 2'b10;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ALUop;
    logic [5:0]   func;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] result;
    logic         hilo_rd;
`ifdef MDU_DIV0_TRAP_EN
    logic         div0;
`endif

    int n_vec = 0;
    int n_err = 0;

    mdu_ctr #(.WIDTH(W), .RTYPE(RT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ALUop   (ALUop),
        .func    (func),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .result  (result),
`ifdef MDU_DIV0_TRAP_EN
        .div0    (div0),
`endif
        .hilo_rd (hilo_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present one start cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        ALUop = op;
        func  = fn;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        func  = 6'b000000;
        ALUop = 2'b00;
    endtask

    // Sample each negedge until done; lat counts samples (first one = 1).
    // Returns one negedge after done, when hi/lo have been written.
    task automatic wait_done(output int lat, output int nbusy, output logic d0);
        bit seen;
        lat   = 0;
        nbusy = 0;
        d0    = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            lat++;
            if (busy) nbusy++;
            if (done) begin
`ifdef MDU_DIV0_TRAP_EN
                d0 = div0;
`endif
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
    endtask

    // Run one multiply/divide and compare hi/lo against hand-computed values.
    task automatic run_op(input string tag, input logic [5:0] fn,
                          input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int lat, nb;
        logic d0;
        issue(RT, fn, va, vb);
        wait_done(lat, nb, d0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int   lat, nb, seen_done;
        logic d0;

        rst_n = 1'b0;
        ALUop = 2'b00;
        func  = 6'b000000;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU latency and busy length
        issue(RT, F_MULTU, 32'hFFFFFFFF, 32'd2);
        check("multu_busy_at_start", 64'(busy), 64'd1);
        wait_done(lat, nb, d0);
        check("multu_latency", 64'(lat), 64'd33);
        check("multu_busy_cycles", 64'(nb), 64'd33);
        check("multu_hi", 64'(hi), 64'h00000001);
        check("multu_lo", 64'(lo), 64'hFFFFFFFE);
        check("multu_idle", 64'(busy), 64'd0);

        // Signed multiply, then HI/LO reads
        run_op("mult_neg", F_MULT, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        ALUop = RT; func = F_MFHI; #1;
        check("mfhi_result", 64'(result), 64'hFFFFFFFF);
        check("mfhi_rd", 64'(hilo_rd), 64'd1);
        func = F_MFLO; #1;
        check("mflo_result", 64'(result), 64'hFFFFFFEB);
        check("mflo_rd", 64'(hilo_rd), 64'd1);
        func = F_MULT; #1;
        check("nonread_result", 64'(result), 64'd0);
        check("nonread_rd", 64'(hilo_rd), 64'd0);
        ALUop = 2'b00; func = 6'b000000;

        // Divides
        run_op("div_neg", F_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("mult_big", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // Divide by zero (prior hi/lo = 40000000 / 00000000)
        issue(RT, F_DIVU, 32'd100, 32'd0);
        wait_done(lat, nb, d0);
        check("divz_latency", 64'(lat), 64'd33);
`ifdef MDU_DIV0_TRAP_EN
        check("divz_flag", 64'(d0), 64'd1);
        check("divz_hi", 64'(hi), 64'h40000000);
        check("divz_lo", 64'(lo), 64'h00000000);
        run_op("divz_s", F_DIV, -32'sd5, 32'd0, 32'h40000000, 32'h00000000);
        issue(RT, F_DIVU, 32'd9, 32'd4);
        wait_done(lat, nb, d0);
        check("div_noflag", 64'(d0), 64'd0);
`else
        check("divz_hi", 64'(hi), 64'd100);
        check("divz_lo", 64'(lo), 64'hFFFFFFFF);
        run_op("divz_s", F_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
`endif

        // Start while busy is ignored
        issue(RT, F_MULT, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        issue(RT, F_DIV, 32'd100, 32'd3);
        wait_done(lat, nb, d0);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd42);
        repeat (3) @(negedge clk);
        check("ign_no_restart", 64'(busy), 64'd0);

        // Async reset mid-operation
        issue(RT, F_MULT, 32'd6, 32'd7);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        // MTHI / MTLO in idle
        issue(RT, F_MTHI, 32'h12345678, 32'd0);
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_done", 64'(done), 64'd0);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(RT, F_MTLO, 32'd55, 32'd0);
        check("mtlo_lo", 64'(lo), 64'd55);
        check("mtlo_hi_kept", 64'(hi), 64'h12345678);

        // MTLO while busy is ignored
        issue(RT, F_MULTU, 32'd2, 32'd3);
        issue(RT, F_MTLO, 32'hDEADBEEF, 32'd0);
        check("mtlo_busy_lo", 64'(lo), 64'd55);
        wait_done(lat, nb, d0);
        check("mtlo_busy_prod_hi", 64'(hi), 64'd0);
        check("mtlo_busy_prod_lo", 64'(lo), 64'd6);

        // Non-R-type start is ignored
        issue(2'b00, F_MULT, 32'd5, 32'd5);
        check("nonr_busy", 64'(busy), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("nonr_no_op", 64'(seen_done), 64'd0);
        check("nonr_lo", 64'(lo), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
